// File: rtl/data_mem_resp_pkg.sv
// data_mem_resp_pkg: shared types and constants for the multi-cycle data-memory responder.
// Optional feature macro used by this block: MEM_ALIGN_CHECK_EN.
package data_mem_resp_pkg;

    localparam int DEF_DEPTH_LOG2 = 8;   // 256 words
    localparam int DEF_LATENCY    = 2;   // cycles from acceptance to done
    localparam int DATA_W         = 16;
    localparam int ADDR_W         = 16;
    localparam int CNT_W          = 4;   // holds LATENCY-1 for LATENCY up to 15

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/data_mem_resp_if.sv
// data_mem_resp_if: request/response bus between the memory stage (master) and the responder (slave).
// Handshake: the master raises req_en with req_wr/req_addr/req_wdata stable; the slave takes it at
// the first rising edge where busy=0, then holds busy until the edge that raises the one-cycle done
// pulse (with rdata/err). req_en seen while busy=1 is ignored; there is no queueing.
interface data_mem_resp_if;
    import data_mem_resp_pkg::*;

    logic              req_en;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req_en, req_wr, req_addr, req_wdata,
        input  busy, done, rdata, err
    );

    modport slave (
        input  req_en, req_wr, req_addr, req_wdata,
        output busy, done, rdata, err
    );

endinterface

// File: rtl/data_mem_resp_array.sv
// data_mem_resp_array: word storage with one write port and one registered read port.
// The whole array and the read register clear asynchronously on rst.
module data_mem_resp_array
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic                  i_rzero,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_rdata;

    // Storage: cleared on reset, written one word per completed write access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register: loads on a read, forced to zero on a suppressed read, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_rzero) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: multi-cycle data-memory responder. Accepts one request at a time, stays busy for
// LATENCY cycles, then performs the access and pulses done (with rdata/err).
// Optional feature macro: MEM_ALIGN_CHECK_EN -- when defined, odd byte addresses suppress the
// access and raise err in the done cycle; when undefined, address bit 0 is ignored and err is 0.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_resp_if.slave bus,
    output state_t         o_state
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_accept;
    logic              w_access;

    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_misalign;
    logic              w_we;
    logic              w_re;
    logic              w_rzero;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] w_rdata;

    // FSM and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, access when the counter reaches zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_en) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = LOAD_VAL;
                end
            end
            WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latches: captured only at acceptance so later bus activity cannot disturb the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_wr    <= bus.req_wr;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end
    end

    // Address bits above the word index never reach the array, so addresses alias.
`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = r_addr[0];
    logic w_unused_addr;
    assign w_unused_addr = ^r_addr[ADDR_W-1:DEPTH_LOG2+1];
`else
    assign w_misalign = 1'b0;
    logic w_unused_addr;
    assign w_unused_addr = ^{r_addr[ADDR_W-1:DEPTH_LOG2+1], r_addr[0]};
`endif

    // A suppressed write simply does not happen; a suppressed read returns zero. A suppressed
    // write leaves rdata alone, since rdata only changes when a read completes.
    assign w_we    = w_access &  r_wr & ~w_misalign;
    assign w_re    = w_access & ~r_wr & ~w_misalign;
    assign w_rzero = w_access & ~r_wr &  w_misalign;

    // Completion flags: registered so done/err rise on the same edge that drops busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_access;
            r_err  <= w_access & w_misalign;
        end
    end

    data_mem_resp_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_rzero (w_rzero),
        .i_addr  (r_addr[DEPTH_LOG2:1]),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign bus.busy  = (r_state == WAIT);
    assign bus.done  = r_done;
    assign bus.err   = r_err;
    assign bus.rdata = w_rdata;
    assign o_state   = r_state;

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed bench for data_mem_resp with three instances (LATENCY 1, 2 and 4)
// sharing one clock and reset. Inputs change and outputs are sampled 1ns after the rising edge.
module tb_data_mem_resp;
    import data_mem_resp_pkg::*;

    logic   clk;
    logic   rst;
    state_t st1, st2, st4;
    int     n_checks;
    int     n_fail;

    data_mem_resp_if m1 ();
    data_mem_resp_if m2 ();
    data_mem_resp_if m4 ();

    data_mem_resp #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(m1), .o_state(st1));
    data_mem_resp #(.DEPTH_LOG2(8), .LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(m2), .o_state(st2));
    data_mem_resp #(.DEPTH_LOG2(8), .LATENCY(4)) u_dut4 (.clk(clk), .rst(rst), .bus(m4), .o_state(st4));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int sel, input logic en, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wdata);
        case (sel)
            1: begin m1.req_en = en; m1.req_wr = wr; m1.req_addr = addr; m1.req_wdata = wdata; end
            2: begin m2.req_en = en; m2.req_wr = wr; m2.req_addr = addr; m2.req_wdata = wdata; end
            default: begin m4.req_en = en; m4.req_wr = wr; m4.req_addr = addr; m4.req_wdata = wdata; end
        endcase
    endtask

    // Present a request for one edge (the instance must be idle), then drop req_en.
    task automatic issue(input int sel, input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        drive(sel, 1'b1, wr, addr, wdata);
        @(posedge clk); #1;
        drive(sel, 1'b0, wr, addr, wdata);
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 1) ? m1.done : (sel == 2) ? m2.done : m4.done;
    endfunction

    // Edges until done is seen; -1 if it never appears within max edges.
    task automatic wait_done(input int sel, input int max, output int cycles);
        cycles = -1;
        for (int n = 1; n <= max; n++) begin
            @(posedge clk); #1;
            if (get_done(sel)) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic count_dones(input int sel, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (get_done(sel)) cnt++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        n_checks++; if (m2.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", m2.busy); end
        n_checks++; if (m2.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", m2.done); end
        n_checks++; if (m2.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", m2.err); end
        n_checks++; if (m2.rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h want 0000", m2.rdata); end
        n_checks++; if (st2 !== IDLE) begin n_fail++; $display("FAIL rst_state: got %b want IDLE", st2); end
    endtask

    task automatic test_write_read;
        int c;
        issue(2, 1'b1, 16'h0010, 16'hBEEF);
        n_checks++; if (m2.busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b want 1", m2.busy); end
        n_checks++; if (st2 !== WAIT) begin n_fail++; $display("FAIL wr_state: got %b want WAIT", st2); end
        wait_done(2, 10, c);
        n_checks++; if (c !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d want 2", c); end
        n_checks++; if (m2.busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_at_done: got %b want 0", m2.busy); end
        n_checks++; if (m2.rdata !== 16'h0000) begin n_fail++; $display("FAIL wr_rdata_held: got %h want 0000", m2.rdata); end
        @(posedge clk); #1;
        n_checks++; if (m2.done !== 1'b0) begin n_fail++; $display("FAIL wr_done_pulse: got %b want 0", m2.done); end
        issue(2, 1'b0, 16'h0010, 16'h0000);
        wait_done(2, 10, c);
        n_checks++; if (c !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d want 2", c); end
        n_checks++; if (m2.rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h want beef", m2.rdata); end
        n_checks++; if (m2.err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", m2.err); end
    endtask

    // Reset raised between edges while a read is in flight; outputs must clear without a clock edge.
    task automatic test_reset_async;
        issue(2, 1'b0, 16'h0010, 16'h0000);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (m2.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", m2.busy); end
        n_checks++; if (m2.done !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %b want 0", m2.done); end
        n_checks++; if (m2.err !== 1'b0) begin n_fail++; $display("FAIL arst_err: got %b want 0", m2.err); end
        n_checks++; if (m2.rdata !== 16'h0000) begin n_fail++; $display("FAIL arst_rdata: got %h want 0000", m2.rdata); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_busy_ignore;
        int c;
        int nd;
        drive(2, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b1, 16'h0010, 16'h1234);
        @(posedge clk); #1;
        nd = m2.done ? 1 : 0;
        drive(2, 1'b0, 1'b1, 16'h0010, 16'h1234);
        count_dones(2, 6, c);
        nd += c;
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", nd); end
        issue(2, 1'b0, 16'h0010, 16'h0000);
        wait_done(2, 10, c);
        n_checks++; if (m2.rdata !== 16'hBEEF) begin n_fail++; $display("FAIL busy_rdata: got %h want beef", m2.rdata); end
    endtask

    task automatic test_addr_wrap;
        int c;
        issue(2, 1'b1, 16'h0202, 16'h5A5A);
        wait_done(2, 10, c);
        issue(2, 1'b0, 16'h0002, 16'h0000);
        wait_done(2, 10, c);
        n_checks++; if (c !== 2) begin n_fail++; $display("FAIL wrap_latency: got %0d want 2", c); end
        n_checks++; if (m2.rdata !== 16'h5A5A) begin n_fail++; $display("FAIL wrap_rdata: got %h want 5a5a", m2.rdata); end
    endtask

    task automatic test_misalign;
        int c;
        issue(2, 1'b1, 16'h0010, 16'h1111);
        wait_done(2, 10, c);
        issue(2, 1'b0, 16'h0011, 16'h0000);
        wait_done(2, 10, c);
        n_checks++; if (c !== 2) begin n_fail++; $display("FAIL mis_latency: got %0d want 2", c); end
`ifdef MEM_ALIGN_CHECK_EN
        n_checks++; if (m2.err !== 1'b1) begin n_fail++; $display("FAIL mis_rd_err: got %b want 1", m2.err); end
        n_checks++; if (m2.rdata !== 16'h0000) begin n_fail++; $display("FAIL mis_rd_rdata: got %h want 0000", m2.rdata); end
        issue(2, 1'b1, 16'h0011, 16'h2222);
        wait_done(2, 10, c);
        n_checks++; if (m2.err !== 1'b1) begin n_fail++; $display("FAIL mis_wr_err: got %b want 1", m2.err); end
        issue(2, 1'b0, 16'h0010, 16'h0000);
        wait_done(2, 10, c);
        n_checks++; if (m2.rdata !== 16'h1111) begin n_fail++; $display("FAIL mis_wr_kept: got %h want 1111", m2.rdata); end
        n_checks++; if (m2.err !== 1'b0) begin n_fail++; $display("FAIL mis_aligned_err: got %b want 0", m2.err); end
`else
        n_checks++; if (m2.err !== 1'b0) begin n_fail++; $display("FAIL mis_rd_err: got %b want 0", m2.err); end
        n_checks++; if (m2.rdata !== 16'h1111) begin n_fail++; $display("FAIL mis_rd_rdata: got %h want 1111", m2.rdata); end
`endif
    endtask

    // Next request presented during the done cycle: one access every LATENCY+1 cycles.
    task automatic test_back_to_back;
        int c;
        issue(2, 1'b1, 16'h0030, 16'h7E57);
        wait_done(2, 10, c);
        n_checks++; if (m2.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_in_done: got %b want 0", m2.busy); end
        issue(2, 1'b0, 16'h0030, 16'h0000);
        n_checks++; if (m2.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b want 1", m2.busy); end
        wait_done(2, 10, c);
        n_checks++; if (c !== 2) begin n_fail++; $display("FAIL b2b_latency: got %0d want 2", c); end
        n_checks++; if (m2.rdata !== 16'h7E57) begin n_fail++; $display("FAIL b2b_rdata: got %h want 7e57", m2.rdata); end
    endtask

    task automatic test_latency1;
        int c;
        issue(1, 1'b1, 16'h0004, 16'hA1A1);
        n_checks++; if (m1.busy !== 1'b1) begin n_fail++; $display("FAIL l1_busy: got %b want 1", m1.busy); end
        wait_done(1, 10, c);
        n_checks++; if (c !== 1) begin n_fail++; $display("FAIL l1_latency: got %0d want 1", c); end
        n_checks++; if (m1.busy !== 1'b0) begin n_fail++; $display("FAIL l1_busy_at_done: got %b want 0", m1.busy); end
        issue(1, 1'b0, 16'h0004, 16'h0000);
        wait_done(1, 10, c);
        n_checks++; if (m1.rdata !== 16'hA1A1) begin n_fail++; $display("FAIL l1_rdata: got %h want a1a1", m1.rdata); end
    endtask

    task automatic test_latency4;
        int c;
        issue(4, 1'b1, 16'h0040, 16'hCAFE);
        wait_done(4, 10, c);
        n_checks++; if (c !== 4) begin n_fail++; $display("FAIL l4_wr_latency: got %0d want 4", c); end
        issue(4, 1'b0, 16'h0040, 16'h0000);
        wait_done(4, 10, c);
        n_checks++; if (c !== 4) begin n_fail++; $display("FAIL l4_rd_latency: got %0d want 4", c); end
        n_checks++; if (m4.rdata !== 16'hCAFE) begin n_fail++; $display("FAIL l4_rdata: got %h want cafe", m4.rdata); end
    endtask

    task automatic test_reset_mid;
        int c;
        issue(4, 1'b1, 16'h0020, 16'hCAFE);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        n_checks++; if (m4.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", m4.busy); end
        n_checks++; if (st4 !== IDLE) begin n_fail++; $display("FAIL mid_state: got %b want IDLE", st4); end
        @(posedge clk); #1 rst = 1'b0;
        count_dones(4, 6, c);
        n_checks++; if (c !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d want 0", c); end
        issue(4, 1'b0, 16'h0020, 16'h0000);
        wait_done(4, 10, c);
        n_checks++; if (c !== 4) begin n_fail++; $display("FAIL mid_rd_latency: got %0d want 4", c); end
        n_checks++; if (m4.rdata !== 16'h0000) begin n_fail++; $display("FAIL mid_rdata: got %h want 0000", m4.rdata); end
        issue(4, 1'b0, 16'h0040, 16'h0000);
        wait_done(4, 10, c);
        n_checks++; if (m4.rdata !== 16'h0000) begin n_fail++; $display("FAIL mid_array_clear: got %h want 0000", m4.rdata); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(4, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #12;
        test_reset;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        test_write_read;
        test_reset_async;
        test_busy_ignore;
        test_addr_wrap;
        test_misalign;
        test_back_to_back;
        test_latency1;
        test_latency4;
        test_reset_mid;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
